prng_roll_ctrl: RTL and testbench

Sequencing controller for the 8-bit LFSR random-number datapath that drives the two seven-segment digits. It turns a user "roll" request into a timed burst of LFSR steps, loads user seeds, publishes a slowly animated result while rolling, then freezes and flags the final value for the HEX decoders. It sits between the top-level pin inputs (EN, roll button, seed switches) and the PRNG core plus display encoders.

---
 rtl/prng_roll_ctrl.sv | 139 +++++++++++++
 tb/tb_prng_roll_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prng_roll_ctrl.sv
// Roll sequencer for the 8-bit LFSR dice datapath: seeds the LFSR, runs a timed burst of steps,
// animates the result on display ticks and freezes the final value. Optional macro: PRNG_DICE_EN.
module prng_roll_ctrl #(
    parameter int PRESCALE   = 4,
    parameter int ROLL_TICKS = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       EN,
    input  logic       roll,
    input  logic       seed_load,
    input  logic [7:0] seed_in,
    input  logic [7:0] lfsr_q,
    output logic       lfsr_step,
    output logic       lfsr_load,
    output logic [7:0] lfsr_seed,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       tick
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int TW = $clog2(ROLL_TICKS + 1);

    typedef enum logic [2:0] {IDLE, SEED, ROLL, LATCH, HOLD} state_t;

    state_t        state_reg, state_next;
    logic          roll_d_reg;
    logic [PW-1:0] presc_reg;
    logic [TW-1:0] tcnt_reg;
    logic [7:0]    lfsr_seed_reg;
    logic [7:0]    result_reg;
    logic          result_valid_reg;
    logic          busy_reg;
    logic          tick_reg;

    logic          rise;
    logic          wrap;
    logic          last_tick;
    logic [7:0]    mapped;

    assign rise      = roll && !roll_d_reg;
    assign wrap      = (presc_reg == PW'(PRESCALE - 1));
    assign last_tick = (tcnt_reg == TW'(ROLL_TICKS - 1));

`ifdef PRNG_DICE_EN
    assign mapped = {5'd0, 3'(lfsr_q % 8'd6) + 3'd1};
`else
    assign mapped = lfsr_q;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (EN) begin
            case (state_reg)
                IDLE, HOLD: begin
                    // Seed request beats a simultaneous roll edge.
                    if (seed_load) begin
                        state_next = SEED;
                    end else if (rise) begin
                        state_next = ROLL;
                    end
                end
                SEED:    state_next = IDLE;
                ROLL:    if (wrap && last_tick) state_next = LATCH;
                LATCH:   state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        lfsr_step = EN && (state_reg == ROLL);
        lfsr_load = EN && (state_reg == SEED);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            roll_d_reg       <= 1'b0;
            presc_reg        <= '0;
            tcnt_reg         <= '0;
            lfsr_seed_reg    <= 8'h00;
            result_reg       <= 8'h00;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            tick_reg         <= 1'b0;
        end else if (EN) begin
            roll_d_reg <= roll;
            tick_reg   <= 1'b0;
            busy_reg   <= (state_next == SEED) || (state_next == ROLL) || (state_next == LATCH);
            case (state_reg)
                IDLE, HOLD: begin
                    if (seed_load) begin
                        // An all-zero seed would lock the LFSR.
                        lfsr_seed_reg    <= (seed_in == 8'h00) ? 8'h01 : seed_in;
                        result_valid_reg <= 1'b0;
                    end else if (rise) begin
                        presc_reg        <= '0;
                        tcnt_reg         <= '0;
                        result_valid_reg <= 1'b0;
                    end
                end
                ROLL: begin
                    if (wrap) begin
                        presc_reg  <= '0;
                        tick_reg   <= 1'b1;
                        result_reg <= mapped;
                        if (tcnt_reg != TW'(ROLL_TICKS)) begin
                            tcnt_reg <= tcnt_reg + TW'(1);
                        end
                    end else begin
                        presc_reg <= presc_reg + PW'(1);
                    end
                end
                LATCH: begin
                    result_reg       <= mapped;
                    result_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign lfsr_seed    = lfsr_seed_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign busy         = busy_reg;
    assign tick         = tick_reg;
endmodule

// File: tb/tb_prng_roll_ctrl.sv
// Scoreboard bench for prng_roll_ctrl: stimulus pushes expected tick/final/load events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_prng_roll_ctrl;
    logic       CLK = 1'b0;
    logic       reset;
    logic       EN;
    logic       roll;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [7:0] lfsr_q = 8'h00;
    logic       lfsr_step;
    logic       lfsr_load;
    logic [7:0] lfsr_seed;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       tick;

    localparam int K_TICK  = 0;
    localparam int K_FINAL = 1;
    localparam int K_LOAD  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   passed   = 0;
    int   cyc      = 0;
    int   step_cnt = 0;
    int   load_cnt = 0;
    logic rv_prev  = 1'b0;

    prng_roll_ctrl #(.PRESCALE(4), .ROLL_TICKS(8)) dut (
        .CLK(CLK), .reset(reset), .EN(EN), .roll(roll), .seed_load(seed_load),
        .seed_in(seed_in), .lfsr_q(lfsr_q), .lfsr_step(lfsr_step), .lfsr_load(lfsr_load),
        .lfsr_seed(lfsr_seed), .result(result), .result_valid(result_valid),
        .busy(busy), .tick(tick)
    );

    always #5 CLK = ~CLK;

    // Stand-in LFSR: a counter makes every sampled value easy to predict by hand.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (lfsr_load) lfsr_q <= lfsr_seed;
        else if (lfsr_step) lfsr_q <= lfsr_q + 8'd1;
        if (lfsr_step) step_cnt <= step_cnt + 1;
        if (lfsr_load) load_cnt <= load_cnt + 1;
    end

    function automatic logic [7:0] map_ref(input logic [7:0] x);
`ifdef PRNG_DICE_EN
        return 8'((x % 8'd6) + 8'd1);
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
            $display("check %-16s got 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pop(input int kind, input logic [7:0] val);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_evt", kind, -1);
        end else begin
            e = sb.pop_front();
            check("evt_kind", kind, e.kind);
            check("evt_cycle", cyc, e.cyc);
            check("evt_value", int'(val), int'(e.val));
        end
    endtask

    always @(negedge CLK) begin
        if (!reset) begin
            if (tick) pop(K_TICK, result);
            if (result_valid && !rv_prev) pop(K_FINAL, result);
            if (lfsr_load) pop(K_LOAD, lfsr_seed);
        end
        rv_prev = result_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Cycle k after roll edge 0 is seen at cyc == t0 + k; ticks at cycles shifted by EN stalls.
    task automatic push_roll(input int t0, input logic [7:0] base, input int shift_from,
                             input int shift, input int n_ticks);
        int k;
        for (int m = 1; m <= n_ticks; m++) begin
            k = 4 * m + 1;
            sb.push_back('{K_TICK, t0 + k + ((k >= shift_from) ? shift : 0),
                           map_ref(base + 8'(k - 2))});
        end
        if (n_ticks == 8) sb.push_back('{K_FINAL, t0 + 34 + shift, map_ref(base + 8'd32)});
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!result_valid && n < max) begin
            step(1);
            n++;
        end
        check("roll_done", int'(result_valid), 1);
    endtask

    task automatic do_seed(input logic [7:0] s, input logic [7:0] exp_seed);
        seed_in   = s;
        seed_load = 1'b1;
        sb.push_back('{K_LOAD, cyc + 1, exp_seed});
        step(1);
        seed_load = 1'b0;
        check("seed_busy", int'(busy), 1);
        check("seed_load_hi", int'(lfsr_load), 1);
        step(1);
        check("seed_load_lo", int'(lfsr_load), 0);
        check("seed_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s0;
        reset = 1'b1; EN = 1'b1; roll = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
        step(2);
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step", int'(lfsr_step), 0);
        check("rst_seed", int'(lfsr_seed), 0);
        reset = 1'b0;
        step(2);

        do_seed(8'h00, 8'h01);
        do_seed(8'h5A, 8'h5A);
        check("load_count", load_cnt, 2);

        // Roll 1; roll stays high afterwards.
        roll = 1'b1; t0 = cyc; s0 = step_cnt;
        push_roll(t0, 8'h5A, 0, 0, 8);
        step(1);
        check("first_step", int'(lfsr_step), 1);
        check("roll_busy", int'(busy), 1);
        wait_valid(60);
        check("roll1_cycle", cyc, t0 + 34);
        check("roll1_steps", step_cnt - s0, 32);
        check("roll1_result", int'(result), int'(map_ref(8'h7A)));
        step(10);
        check("hold_valid", int'(result_valid), 1);
        check("hold_nostep", step_cnt - s0, 32);
        check("hold_busy", int'(busy), 0);

        // Roll 2 with a 10-cycle EN stall starting in cycle 10.
        roll = 1'b0; step(1);
        roll = 1'b1; t0 = cyc; s0 = step_cnt;
        push_roll(t0, 8'h7A, 13, 10, 8);
        step(1);
        check("reroll_vclr", int'(result_valid), 0);
        step(9);
        EN = 1'b0;
        step(5);
        check("en_step", int'(lfsr_step), 0);
        check("en_tick", int'(tick), 0);
        check("en_busy", int'(busy), 1);
        step(5);
        EN = 1'b1;
        wait_valid(80);
        check("roll2_cycle", cyc, t0 + 44);
        check("roll2_steps", step_cnt - s0, 32);

        // Simultaneous seed and roll edge in HOLD: seed wins.
        roll = 1'b0; step(1);
        roll = 1'b1; s0 = step_cnt;
        do_seed(8'h33, 8'h33);
        check("seed_vclr", int'(result_valid), 0);
        step(3);
        check("edge_dropped", step_cnt - s0, 0);

        // Roll 3 aborted by reset in cycle 12.
        roll = 1'b0; step(1);
        roll = 1'b1; t0 = cyc;
        push_roll(t0, 8'h33, 0, 0, 2);
        step(12);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_step", int'(lfsr_step), 0);
        roll = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        check("post_rst_idle", int'(busy), 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
